// File: rtl/vram_pkg.sv
// vram_pkg: shared ZBT frame-buffer constants and the address packing used by capture and display.
package vram_pkg;
  localparam int VRAM_ADDR_W = 19;
  localparam int VRAM_DATA_W = 36;
  localparam int PIXEL_W = 18;
  localparam int ZBT_READ_LATENCY = 2;
  localparam int READER_PIPE = 4;
  function automatic logic [VRAM_ADDR_W-1:0] vram_pack_addr(input logic [8:0] line, input logic field, input logic [8:0] word);
    return {line, field, word};
  endfunction
endpackage

// File: rtl/delay_line.sv
// delay_line: W-bit wide, D-deep shift register with synchronous reset.
module delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [D-1:0][W-1:0] sr;
  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[D-1];
endmodule

// File: rtl/vram_frame_reader.sv
// vram_frame_reader: owns the ZBT port, gives capture writes priority and streams the stored frame aligned to XVGA timing.
module vram_frame_reader
  import vram_pkg::*;
#(
  parameter int H_ACTIVE = 720,
  parameter int V_ACTIVE = 480,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            hcount,
  input  logic [9:0]             vcount,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   blank,
  input  logic [VRAM_ADDR_W-1:0] ntsc_addr,
  input  logic [VRAM_DATA_W-1:0] ntsc_data,
  input  logic                   ntsc_we,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic                   vram_we,
  output logic [VRAM_DATA_W-1:0] vram_write_data,
  input  logic [VRAM_DATA_W-1:0] vram_read_data,
  output logic [PIXEL_W-1:0]     pixel,
  output logic                   pixel_valid,
  output logic                   phsync,
  output logic                   pvsync,
  output logic                   pblank
);
  logic [11:0] cx;
  logic [10:0] ry;
  logic win, w_d, h_d, l_d, hs_d, vs_d, bl_d;
  logic [5:0] tap;
  // The extra top bit is the borrow, so a negative offset falls outside the window.
  assign cx = {1'b0, hcount} - 12'(X_ORIGIN);
  assign ry = {1'b0, vcount} - 11'(Y_ORIGIN);
  assign win = !cx[11] && cx[10:0] < 11'(H_ACTIVE) && !ry[10] && ry[9:0] < 10'(V_ACTIVE) && !blank;
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_we <= 1'b0;
      vram_addr <= '0;
      vram_write_data <= '0;
    end else begin
      vram_we <= ntsc_we;
      vram_addr <= ntsc_we ? ntsc_addr : vram_pack_addr(ry[9:1], ry[0], cx[9:1]);
      if (ntsc_we) vram_write_data <= ntsc_data;
    end
  end
  // The output register below supplies the last pipeline stage.
  delay_line #(.W(6), .D(READER_PIPE-1)) u_dl (
    .clk(clk),
    .reset(reset),
    .d({win, cx[0], ntsc_we, hsync, vsync, blank}),
    .q(tap)
  );
  assign {w_d, h_d, l_d, hs_d, vs_d, bl_d} = tap;
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel <= '0;
      pixel_valid <= 1'b0;
      phsync <= 1'b0;
      pvsync <= 1'b0;
      pblank <= 1'b0;
    end else begin
      pixel <= l_d ? pixel : !w_d ? '0 : h_d ? vram_read_data[2*PIXEL_W-1:PIXEL_W] : vram_read_data[PIXEL_W-1:0];
      pixel_valid <= w_d;
      phsync <= hs_d;
      pvsync <= vs_d;
      pblank <= bl_d;
    end
  end
endmodule
